ssd_scan_decoder: RTL and testbench

- Receive-side counterpart of the seven-segment encoder: it watches the active-low anode, cathode and dp lines of a multiplexed 8-digit display and rebuilds the hex value shown on each digit.
- Used for on-board loopback checking and for self-test of the display path on the Nexys A7.
- Each digit is captured only after its pattern has been stable for a programmable number of clocks. Illegal patterns and ghosting are flagged.

---
 rtl/ssd_pkg.sv | 28 ++
 rtl/ssd_seg_decode.sv | 30 +++
 rtl/ssd_scan_decoder.sv | 105 ++++++++++
 tb/tb_ssd_scan_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment patterns, decode result type and scan FSM states
package ssd_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0100111;
  localparam logic [6:0] SEG_B     = 7'b0110011;
  localparam logic [6:0] SEG_C     = 7'b0011101;
  localparam logic [6:0] SEG_D     = 7'b0010110;
  localparam logic [6:0] SEG_E     = 7'b0000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Cathode vector is {g,f,e,d,c,b,a}: segment a at bit 0, g at bit 6
  localparam int CC_BIT_A = 0;
  localparam int CC_BIT_G = 6;
  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_e;
  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       legal;
  } seg_dec_t;
endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: active-low cathode pattern to {nibble, blank, legal}
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] cc_i,
  output seg_dec_t   dec_o
);
  always_comb begin
    dec_o = '{nib: 4'hF, blank: 1'b0, legal: 1'b0};
    case (cc_i)
      SEG_0:     dec_o = '{nib: 4'h0, blank: 1'b0, legal: 1'b1};
      SEG_1:     dec_o = '{nib: 4'h1, blank: 1'b0, legal: 1'b1};
      SEG_2:     dec_o = '{nib: 4'h2, blank: 1'b0, legal: 1'b1};
      SEG_3:     dec_o = '{nib: 4'h3, blank: 1'b0, legal: 1'b1};
      SEG_4:     dec_o = '{nib: 4'h4, blank: 1'b0, legal: 1'b1};
      SEG_5:     dec_o = '{nib: 4'h5, blank: 1'b0, legal: 1'b1};
      SEG_6:     dec_o = '{nib: 4'h6, blank: 1'b0, legal: 1'b1};
      SEG_7:     dec_o = '{nib: 4'h7, blank: 1'b0, legal: 1'b1};
      SEG_8:     dec_o = '{nib: 4'h8, blank: 1'b0, legal: 1'b1};
      SEG_9:     dec_o = '{nib: 4'h9, blank: 1'b0, legal: 1'b1};
      SEG_A:     dec_o = '{nib: 4'hA, blank: 1'b0, legal: 1'b1};
      SEG_B:     dec_o = '{nib: 4'hB, blank: 1'b0, legal: 1'b1};
      SEG_C:     dec_o = '{nib: 4'hC, blank: 1'b0, legal: 1'b1};
      SEG_D:     dec_o = '{nib: 4'hD, blank: 1'b0, legal: 1'b1};
      SEG_E:     dec_o = '{nib: 4'hE, blank: 1'b0, legal: 1'b1};
      SEG_BLANK: dec_o = '{nib: 4'hF, blank: 1'b1, legal: 1'b1};
      default:   dec_o = '{nib: 4'hF, blank: 1'b0, legal: 1'b0};
    endcase
  end
endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder: rebuilds per-digit hex values from a multiplexed active-low display scan
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    ssd_scan_decoder_port_clk,
  input  logic                    ssd_scan_decoder_port_rst,
  input  logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_an,
  input  logic [6:0]              ssd_scan_decoder_port_cc,
  input  logic                    ssd_scan_decoder_port_dp,
  input  logic                    ssd_scan_decoder_port_err_clr,
  output logic [4*NUM_DIGITS-1:0] ssd_scan_decoder_port_digits,
  output logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_dps,
  output logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_valid,
  output logic [NUM_DIGITS-1:0]   ssd_scan_decoder_port_blank,
  output logic                    ssd_scan_decoder_port_upd,
  output logic [IW-1:0]           ssd_scan_decoder_port_upd_idx,
  output logic                    ssd_scan_decoder_port_err
);
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_CAP = 4'(STABLE_CYCLES - 1);
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              cc_q;
  logic                    dp_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dps_q, valid_q, blank_q;
  logic                    upd_q, err_q;
  logic [IW-1:0]           upd_idx_q, idx;
  logic [NUM_DIGITS-1:0]   low;
  logic                    match, one_hot, cap, wr, err_evt;
  seg_dec_t                dec;

  ssd_seg_decode u_dec (.cc_i(cc_q), .dec_o(dec));

  assign match   = {ssd_scan_decoder_port_an, ssd_scan_decoder_port_cc, ssd_scan_decoder_port_dp}
                   == {an_q, cc_q, dp_q};
  assign low     = ~an_q;
  assign one_hot = (low != '0) && ((low & (low - NUM_DIGITS'(1))) == '0);
  assign cap     = (state_q == TRACK) && match && (cnt_q == CNT_CAP);
  assign wr      = cap && one_hot && dec.legal;
  // Ghosting (several anodes low) and unknown cathode patterns both count as errors
  assign err_evt = cap && !(one_hot && dec.legal);

  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) idx = low[k] ? IW'(k) : idx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!match) begin
      state_d = (&ssd_scan_decoder_port_an) ? IDLE : TRACK;
      cnt_d   = '0;
    end else if (state_q != IDLE) begin
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
      state_d = cap ? HELD : state_q;
    end
  end

  always_ff @(posedge ssd_scan_decoder_port_clk) begin
    if (ssd_scan_decoder_port_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      an_q      <= '1;
      cc_q      <= '1;
      dp_q      <= 1'b1;
      digits_q  <= '0;
      dps_q     <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      an_q    <= ssd_scan_decoder_port_an;
      cc_q    <= ssd_scan_decoder_port_cc;
      dp_q    <= ssd_scan_decoder_port_dp;
      upd_q   <= wr;
      err_q   <= err_evt | (err_q & ~ssd_scan_decoder_port_err_clr);
      if (wr) begin
        upd_idx_q             <= idx;
        digits_q[4*idx +: 4]  <= dec.nib;
        dps_q[idx]            <= ~dp_q;
        blank_q[idx]          <= dec.blank;
        valid_q[idx]          <= 1'b1;
      end
    end
  end

  assign ssd_scan_decoder_port_digits  = digits_q;
  assign ssd_scan_decoder_port_dps     = dps_q;
  assign ssd_scan_decoder_port_valid   = valid_q;
  assign ssd_scan_decoder_port_blank   = blank_q;
  assign ssd_scan_decoder_port_upd     = upd_q;
  assign ssd_scan_decoder_port_upd_idx = upd_idx_q;
  assign ssd_scan_decoder_port_err     = err_q;
endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder: directed scan vectors with a queue scoreboard on upd pulses
module tb_ssd_scan_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  cc = 7'h7F;
  logic        dp = 1'b1;
  logic        err_clr = 1'b0;
  logic [31:0] digits;
  logic [7:0]  dps, valid, blank;
  logic        upd, err;
  logic [2:0]  upd_idx;
  int          n_vec = 0;
  int          n_bad = 0;
  int          upd_seen = 0;
  int          base;
  logic [6:0]  seg [16];
  typedef struct {
    int         idx;
    logic [3:0] nib;
    logic       dp;
    logic       blank;
  } exp_t;
  exp_t        q [$];

  ssd_scan_decoder dut (
    .ssd_scan_decoder_port_clk(clk),
    .ssd_scan_decoder_port_rst(rst),
    .ssd_scan_decoder_port_an(an),
    .ssd_scan_decoder_port_cc(cc),
    .ssd_scan_decoder_port_dp(dp),
    .ssd_scan_decoder_port_err_clr(err_clr),
    .ssd_scan_decoder_port_digits(digits),
    .ssd_scan_decoder_port_dps(dps),
    .ssd_scan_decoder_port_valid(valid),
    .ssd_scan_decoder_port_blank(blank),
    .ssd_scan_decoder_port_upd(upd),
    .ssd_scan_decoder_port_upd_idx(upd_idx),
    .ssd_scan_decoder_port_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [7:0] a, input logic [6:0] c, input logic d, input int n);
    an = a;
    cc = c;
    dp = d;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [3:0] v, input logic d, input logic b);
    exp_t e;
    e.idx = i;
    e.nib = v;
    e.dp = d;
    e.blank = b;
    q.push_back(e);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (upd) begin
      upd_seen++;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_upd: got idx %0d expected no update", upd_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_idx", 32'(upd_idx), 32'(e.idx));
        chk("upd_digit", 32'(digits[4*e.idx +: 4]), 32'(e.nib));
        chk("upd_dp", 32'(dps[e.idx]), 32'(e.dp));
        chk("upd_blank", 32'(blank[e.idx]), 32'(e.blank));
        chk("upd_valid", 32'(valid[e.idx]), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100; seg[3] = 7'b0110000;
    seg[4] = 7'b0011001; seg[5] = 7'b0010010; seg[6] = 7'b0000010; seg[7] = 7'b1111000;
    seg[8] = 7'b0000000; seg[9] = 7'b0011000; seg[10] = 7'b0100111; seg[11] = 7'b0110011;
    seg[12] = 7'b0011101; seg[13] = 7'b0010110; seg[14] = 7'b0000111; seg[15] = 7'b1111111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_digits", digits, 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_upd", 32'(upd), 32'h0);
    rst = 1'b0;
    // single digit 2 with dp lit on anode 0
    push(0, 4'h2, 1'b1, 1'b0);
    hold(8'hFE, seg[2], 1'b0, 6);
    chk("t1_digit0", 32'(digits[3:0]), 32'h2);
    chk("t1_dps", 32'(dps), 32'h01);
    chk("t1_valid", 32'(valid), 32'h01);
    chk("t1_err", 32'(err), 32'h0);
    chk("t1_upd_count", 32'(upd_seen), 32'd1);
    hold(8'hFF, 7'h7F, 1'b1, 2);
    // full scan, anode a shows 8-a, no blanking gap
    base = upd_seen;
    for (int a = 7; a >= 0; a--) begin
      push(a, 4'(8 - a), 1'b0, 1'b0);
      hold(~(8'h01 << a), seg[8 - a], 1'b1, 10);
    end
    chk("t2_digits", digits, 32'h12345678);
    chk("t2_valid", 32'(valid), 32'hFF);
    chk("t2_dps", 32'(dps), 32'h00);
    chk("t2_err", 32'(err), 32'h0);
    chk("t2_upd_count", 32'(upd_seen - base), 32'd8);
    // illegal pattern after a reset-free gap: use a fresh valid mask via digit 2 check
    hold(8'hFF, 7'h7F, 1'b1, 2);
    base = upd_seen;
    hold(8'hFB, 7'b1010101, 1'b1, 8);
    chk("t3_err_set", 32'(err), 32'h1);
    chk("t3_no_upd", 32'(upd_seen - base), 32'd0);
    chk("t3_digit2_kept", 32'(digits[11:8]), 32'h6);
    pulse_clr();
    chk("t3_err_clr", 32'(err), 32'h0);
    // ghosting: two anodes low
    hold(8'hFF, 7'h7F, 1'b1, 2);
    hold(8'hF3, seg[0], 1'b1, 8);
    chk("t4_err_ghost", 32'(err), 32'h1);
    chk("t4_digits_kept", digits, 32'h12345678);
    chk("t4_no_upd", 32'(upd_seen - base), 32'd0);
    pulse_clr();
    chk("t4_err_clr", 32'(err), 32'h0);
    hold(8'hFF, 7'h7F, 1'b1, 2);
    hold(8'hF3, seg[0], 1'b1, 4);
    chk("t4_err_before", 32'(err), 32'h0);
    pulse_clr();
    chk("t4_set_wins", 32'(err), 32'h1);
    pulse_clr();
    chk("t4_err_clr2", 32'(err), 32'h0);
    // glitching cathodes on anode 1 never settle long enough
    hold(8'hFF, 7'h7F, 1'b1, 2);
    base = upd_seen;
    for (int g = 0; g < 6; g++) hold(8'hFD, (g % 2 == 0) ? seg[9] : seg[8], 1'b1, 2);
    chk("t5_no_capture", 32'(upd_seen - base), 32'd0);
    chk("t5_digit1_kept", 32'(digits[7:4]), 32'h7);
    hold(8'hFD, seg[8], 1'b1, 2);
    push(1, 4'h9, 1'b0, 1'b0);
    hold(8'hFD, seg[9], 1'b1, 5);
    chk("t5_digit1", 32'(digits[7:4]), 32'h9);
    chk("t5_one_upd", 32'(upd_seen - base), 32'd1);
    // reset on edge 4 of a pending capture
    hold(8'hFF, 7'h7F, 1'b1, 2);
    base = upd_seen;
    hold(8'hF7, seg[5], 1'b1, 3);
    rst = 1'b1;
    hold(8'hF7, seg[5], 1'b1, 1);
    rst = 1'b0;
    chk("t6_rst_upd", 32'(upd_seen - base), 32'd0);
    chk("t6_rst_digits", digits, 32'h0);
    chk("t6_rst_valid", 32'(valid), 32'h0);
    chk("t6_rst_dps_blank", 32'({dps, blank}), 32'h0);
    chk("t6_rst_err", 32'(err), 32'h0);
    hold(8'hF7, seg[5], 1'b1, 4);
    chk("t6_not_yet", 32'(valid), 32'h0);
    push(3, 4'h5, 1'b0, 1'b0);
    hold(8'hF7, seg[5], 1'b1, 1);
    chk("t6_valid3", 32'(valid), 32'h08);
    chk("t6_digit3", 32'(digits[15:12]), 32'h5);
    push(3, 4'hF, 1'b0, 1'b1);
    hold(8'hF7, seg[15], 1'b1, 6);
    chk("t6_blank_digit", 32'(digits[15:12]), 32'hF);
    chk("t6_blank_flag", 32'(blank), 32'h08);
    chk("t6_upd_count", 32'(upd_seen - base), 32'd2);
    hold(8'hFF, 7'h7F, 1'b1, 2);
    chk("pending_expect", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
